// File: rtl/f_fetch_npc.sv
// Fetch stage: PC register, next-PC selection from the D-stage branch/jump
// decision (one delay slot), and the F/D pipeline register.
module f_fetch_npc #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic [1:0]  i_npcOp,
  input  logic        i_jumpEn_of_B,
  input  logic [15:0] i_D_imm16,
  input  logic [25:0] i_D_imm26,
  input  logic [31:0] i_D_rsData,
  input  logic [31:0] i_F_instr,
  output logic [31:0] o_F_pc,
  output logic [31:0] o_D_instr,
  output logic [31:0] o_D_pc,
  output logic [31:0] o_D_pc8,
  output logic        o_D_valid
);

  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_J      = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  logic [31:0] pc_q, pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_valid_q, d_valid_d;

  logic [31:0] pc_plus4;
  logic signed [31:0] br_off;
  logic [31:0] target_b;
  logic [31:0] target_j;
  logic [31:0] npc;

  // Redirect targets are relative to the instruction sitting in D, not to the fetch PC.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    br_off   = {{14{i_D_imm16[15]}}, i_D_imm16, 2'b00};
    target_b = d_pc_q + 32'd4 + br_off;
    target_j = {d_pc_q[31:28], i_D_imm26, 2'b00};
    npc      = pc_plus4;
    case (i_npcOp)
      NPC_PC4:    npc = pc_plus4;
      NPC_BRANCH: npc = i_jumpEn_of_B ? target_b : pc_plus4;
      NPC_J:      npc = target_j;
      NPC_JR:     npc = i_D_rsData;
      default:    npc = pc_plus4;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    d_valid_d = d_valid_q;
    if (!i_stall) begin
      pc_d      = npc;
      d_instr_d = i_F_instr;
      d_pc_d    = pc_q;
      d_valid_d = 1'b1;
    end
  end

  // F -> D boundary; reset wins over stall.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q      <= PC_RESET;
      d_instr_q <= 32'd0;
      d_pc_q    <= 32'd0;
      d_valid_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign o_F_pc    = pc_q;
  assign o_D_instr = d_instr_q;
  assign o_D_pc    = d_pc_q;
  assign o_D_pc8   = d_pc_q + 32'd8;
  assign o_D_valid = d_valid_q;

endmodule

// File: tb/tb_f_fetch_npc.sv
// Bench for f_fetch_npc: directed literal checks plus randomized traffic
// compared every cycle against a behavioural fetch model.
module tb_f_fetch_npc;

  localparam logic [31:0] PC_RST = 32'h0000_3000;

  logic        clk;
  logic        i_reset;
  logic        i_stall;
  logic [1:0]  i_npcOp;
  logic        i_jumpEn_of_B;
  logic [15:0] i_D_imm16;
  logic [25:0] i_D_imm26;
  logic [31:0] i_D_rsData;
  logic [31:0] i_F_instr;
  logic [31:0] o_F_pc;
  logic [31:0] o_D_instr;
  logic [31:0] o_D_pc;
  logic [31:0] o_D_pc8;
  logic        o_D_valid;

  int n_chk  = 0;
  int n_fail = 0;

  f_fetch_npc #(.PC_RESET(PC_RST)) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_stall(i_stall),
    .i_npcOp(i_npcOp),
    .i_jumpEn_of_B(i_jumpEn_of_B),
    .i_D_imm16(i_D_imm16),
    .i_D_imm26(i_D_imm26),
    .i_D_rsData(i_D_rsData),
    .i_F_instr(i_F_instr),
    .o_F_pc(o_F_pc),
    .o_D_instr(o_D_instr),
    .o_D_pc(o_D_pc),
    .o_D_pc8(o_D_pc8),
    .o_D_valid(o_D_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synthetic instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign i_F_instr = imem(o_F_pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural PC and the F/D slot contents.
  logic [31:0] m_pc = 32'd0, m_dpc = 32'd0, m_dinstr = 32'd0;
  logic        m_dv = 1'b0;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    logic [31:0] nxt;
    logic [31:0] off;
    if (i_reset) begin
      m_pc = PC_RST; m_dpc = 0; m_dinstr = 0; m_dv = 0; model_ok = 1'b1;
    end else if (!i_stall) begin
      off = {{16{i_D_imm16[15]}}, i_D_imm16};
      case (i_npcOp)
        2'd1:    nxt = i_jumpEn_of_B ? (m_dpc + 32'd4 + off * 32'd4) : (m_pc + 32'd4);
        2'd2:    nxt = (m_dpc & 32'hF000_0000) | ({6'd0, i_D_imm26} * 32'd4);
        2'd3:    nxt = i_D_rsData;
        default: nxt = m_pc + 32'd4;
      endcase
      m_dinstr = imem(m_pc);
      m_dpc    = m_pc;
      m_dv     = 1'b1;
      m_pc     = nxt;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_F_pc",    o_F_pc,    m_pc);
      chk("model_D_pc",    o_D_pc,    m_dpc);
      chk("model_D_instr", o_D_instr, m_dinstr);
      chk("model_D_valid", {31'd0, o_D_valid}, {31'd0, m_dv});
      chk("model_D_pc8",   o_D_pc8,   m_dpc + 32'd8);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_stall = 0; i_npcOp = 0; i_jumpEn_of_B = 0;
    i_D_imm16 = 0; i_D_imm26 = 0; i_D_rsData = 0;
  endtask

  // Reset for two cycles, release, then advance until o_D_pc = 0x3004.
  task automatic go_to_3004(input bit check);
    idle_inputs();
    i_reset = 1;
    step(); step();
    if (check) begin
      chk("rst_F_pc",    o_F_pc,    PC_RST);
      chk("rst_D_valid", {31'd0, o_D_valid}, 32'd0);
      chk("rst_D_instr", o_D_instr, 32'd0);
    end
    i_reset = 0;
    step();
    if (check) begin
      chk("seq1_D_pc",    o_D_pc,    32'h3000);
      chk("seq1_D_valid", {31'd0, o_D_valid}, 32'd1);
      chk("seq1_F_pc",    o_F_pc,    32'h3004);
    end
    step();
    if (check) begin
      chk("seq2_F_pc", o_F_pc, 32'h3008);
      chk("seq2_D_pc", o_D_pc, 32'h3004);
    end
  endtask

  initial begin
    i_reset = 1;
    idle_inputs();

    // Sequential fetch
    go_to_3004(1'b1);
    step();
    chk("seq3_F_pc", o_F_pc, 32'h300C);
    chk("seq3_D_pc", o_D_pc, 32'h3008);

    // Taken branch back to 0x3000; delay slot 0x3008 enters D
    go_to_3004(1'b0);
    i_npcOp = 2'd1; i_D_imm16 = 16'hFFFE; i_jumpEn_of_B = 1;
    step();
    chk("beq_t_F_pc",    o_F_pc,    32'h3000);
    chk("beq_t_D_pc",    o_D_pc,    32'h3008);
    chk("beq_t_D_instr", o_D_instr, imem(32'h3008));

    // Not-taken branch
    go_to_3004(1'b0);
    i_npcOp = 2'd1; i_D_imm16 = 16'hFFFE; i_jumpEn_of_B = 0;
    step();
    chk("beq_nt_F_pc", o_F_pc, 32'h300C);

    // Stall with taken branch in D, redirect on the first non-stall edge
    go_to_3004(1'b0);
    i_npcOp = 2'd1; i_D_imm16 = 16'hFFFE; i_jumpEn_of_B = 1; i_stall = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall_F_pc",    o_F_pc,    32'h3008);
      chk("stall_D_pc",    o_D_pc,    32'h3004);
      chk("stall_D_instr", o_D_instr, imem(32'h3004));
    end
    i_stall = 0;
    step();
    chk("stall_redir_F_pc", o_F_pc, 32'h3000);

    // JR and J targets, link value
    go_to_3004(1'b0);
    chk("pc8", o_D_pc8, 32'h300C);
    i_npcOp = 2'd3; i_D_rsData = 32'h0000_3010;
    step();
    chk("jr_F_pc", o_F_pc, 32'h3010);
    go_to_3004(1'b0);
    i_npcOp = 2'd2; i_D_imm26 = 26'h0000C08;
    step();
    chk("j_F_pc", o_F_pc, 32'h3020);

    // Reset asserted during a stall
    idle_inputs();
    i_stall = 1;
    step();
    i_reset = 1;
    step();
    chk("rst_in_stall_F_pc",    o_F_pc, PC_RST);
    chk("rst_in_stall_D_valid", {31'd0, o_D_valid}, 32'd0);
    i_reset = 0;

    // Randomized traffic; the compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      i_reset       = ($urandom_range(0, 99) == 0);
      i_stall       = ($urandom_range(0, 3) == 0);
      i_npcOp       = 2'($urandom_range(0, 3));
      i_jumpEn_of_B = 1'($urandom_range(0, 1));
      i_D_imm16     = 16'($urandom);
      i_D_imm26     = 26'($urandom);
      i_D_rsData    = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
